modexp_word_bank: RTL

- Word-serial operand/result bank on the exponentiation-core side of the 64-bit load/unload interface; it is the responder to the top-level streamer.
- Receives the message, exponent, modulus, R and T operands one word per strobe, then releases the core on start_compute.
- Collects result words written by the core and streams them back word-serially on get_result.
- All storage is internal synchronous RAM, one bank per operand plus one result bank.

---
 rtl/modexp_word_bank.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/modexp_word_bank.sv
// rtl/modexp_word_bank.sv - word-serial operand/result bank for the modexp core.
// Optional per-word even parity is enabled with WORD_BANK_PARITY_EN.
module modexp_word_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_input,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] m_buf,
    input  logic [DATA_WIDTH-1:0] e_buf,
    input  logic [DATA_WIDTH-1:0] n_buf,
    input  logic [DATA_WIDTH-1:0] r_buf,
    input  logic [DATA_WIDTH-1:0] t_buf,
    input  logic [63:0]           nprime0_in,
    input  logic                  start_compute,
    input  logic                  get_result,
    input  logic [ADDR_W-1:0]     core_raddr,
    output logic [DATA_WIDTH-1:0] core_m,
    output logic [DATA_WIDTH-1:0] core_e,
    output logic [DATA_WIDTH-1:0] core_n,
    output logic [DATA_WIDTH-1:0] core_r,
    output logic [DATA_WIDTH-1:0] core_t,
    input  logic                  core_wen,
    input  logic [ADDR_W-1:0]     core_waddr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    input  logic                  core_done,
    output logic                  core_go,
    output logic [63:0]           nprime0,
    output logic                  load_done,
    output logic [DATA_WIDTH-1:0] res_out,
    output logic                  res_valid,
    output logic [2:0]            bank_state,
    output logic                  error,
    output logic                  parity_err
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_LOAD         = 3'd1,
        ST_LOADED       = 3'd2,
        ST_COMPUTE      = 3'd3,
        ST_RESULT_READY = 3'd4,
        ST_STREAM       = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W-1:0]   rptr;
    logic                issuing;
    logic                op_we;
    logic                res_we;
    logic                violation;

    logic [DATA_WIDTH-1:0] m_ram   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] e_ram   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] n_ram   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] r_ram   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] t_ram   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] res_ram [NUM_WORDS];

    // Stream pipeline: RAM read stage, then output register (two-cycle latency).
    logic [DATA_WIDTH-1:0] res_rd;
    logic                  rd_v;
    logic                  rd_last;
    logic                  res_last;

    assign op_we      = (state == ST_LOAD) && in_valid;
    assign res_we     = (state == ST_COMPUTE) && core_wen;
    assign bank_state = state;

    assign violation = (start_input && (state == ST_LOAD || state == ST_COMPUTE ||
                                        state == ST_STREAM))
                     || (start_compute && state != ST_LOADED)
                     || (get_result && state != ST_RESULT_READY)
                     || (core_wen && state != ST_COMPUTE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            rptr      <= '0;
            issuing   <= 1'b0;
            nprime0   <= '0;
            core_go   <= 1'b0;
            load_done <= 1'b0;
            error     <= 1'b0;
        end else begin
            core_go <= 1'b0;
            if (violation) begin
                error <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_input) begin
                        state   <= ST_LOAD;
                        wptr    <= '0;
                        nprime0 <= nprime0_in;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        wptr <= wptr + 1'b1;
                        if (wptr == LAST_ADDR) begin
                            state     <= ST_LOADED;
                            load_done <= 1'b1;
                        end
                    end
                end
                ST_LOADED: begin
                    if (start_input) begin
                        state     <= ST_LOAD;
                        wptr      <= '0;
                        nprime0   <= nprime0_in;
                        load_done <= 1'b0;
                    end else if (start_compute) begin
                        state     <= ST_COMPUTE;
                        core_go   <= 1'b1;
                        load_done <= 1'b0;
                    end
                end
                ST_COMPUTE: begin
                    if (core_done) begin
                        state <= ST_RESULT_READY;
                    end
                end
                ST_RESULT_READY: begin
                    if (start_input) begin
                        state   <= ST_LOAD;
                        wptr    <= '0;
                        nprime0 <= nprime0_in;
                    end else if (get_result) begin
                        state   <= ST_STREAM;
                        rptr    <= '0;
                        issuing <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (issuing) begin
                        rptr <= rptr + 1'b1;
                        if (rptr == LAST_ADDR) begin
                            issuing <= 1'b0;
                        end
                    end
                    // Leave only once the last word has been presented.
                    if (res_valid && res_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (op_we) begin
            m_ram[wptr] <= m_buf;
            e_ram[wptr] <= e_buf;
            n_ram[wptr] <= n_buf;
            r_ram[wptr] <= r_buf;
            t_ram[wptr] <= t_buf;
        end
        if (res_we) begin
            res_ram[core_waddr] <= core_wdata;
        end
        if (issuing) begin
            res_rd <= res_ram[rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_m <= '0;
            core_e <= '0;
            core_n <= '0;
            core_r <= '0;
            core_t <= '0;
        end else begin
            core_m <= m_ram[core_raddr];
            core_e <= e_ram[core_raddr];
            core_n <= n_ram[core_raddr];
            core_r <= r_ram[core_raddr];
            core_t <= t_ram[core_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v      <= 1'b0;
            rd_last   <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_out   <= '0;
        end else begin
            rd_v      <= issuing;
            rd_last   <= issuing && (rptr == LAST_ADDR);
            res_valid <= rd_v;
            res_last  <= rd_last;
            if (rd_v) begin
                res_out <= res_rd;
            end
        end
    end

`ifdef WORD_BANK_PARITY_EN
    logic [4:0]           op_par  [NUM_WORDS];
    logic                 res_par [NUM_WORDS];
    logic [NUM_WORDS-1:0] op_written;
    logic [NUM_WORDS-1:0] res_written;
    logic                 rd_par;
    logic                 rd_chk;
    logic [4:0]           op_par_calc;

    always_comb begin
        op_par_calc = {^m_ram[core_raddr], ^e_ram[core_raddr], ^n_ram[core_raddr],
                       ^r_ram[core_raddr], ^t_ram[core_raddr]};
    end

    always_ff @(posedge clk) begin
        if (op_we) begin
            op_par[wptr] <= {^m_buf, ^e_buf, ^n_buf, ^r_buf, ^t_buf};
        end
        if (res_we) begin
            res_par[core_waddr] <= ^core_wdata;
        end
        if (issuing) begin
            rd_par <= res_par[rptr];
        end
    end

    // Words never written since reset hold no parity, so they are not checked.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err  <= 1'b0;
            op_written  <= '0;
            res_written <= '0;
            rd_chk      <= 1'b0;
        end else begin
            if (op_we) begin
                op_written[wptr] <= 1'b1;
            end
            if (res_we) begin
                res_written[core_waddr] <= 1'b1;
            end
            rd_chk <= issuing && res_written[rptr];
            if (op_written[core_raddr] && (op_par_calc != op_par[core_raddr])) begin
                parity_err <= 1'b1;
            end
            if (rd_v && rd_chk && ((^res_rd) != rd_par)) begin
                parity_err <= 1'b1;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
